mips_mem_responder: RTL and testbench

Memory-side responder for the single-cycle MIPS core. It answers the core's instruction-fetch port (PC → Instr) and data port (ALUOut/WriteData/MemWrite → ReadData). It also owns a streaming program loader that fills instruction memory after reset while holding the core in reset. It sits beside the core at the top level, and its outputs drive the core's Instr, ReadData and reset inputs.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mips_mem_loader.sv | 65 ++++++
 rtl/mips_mem_responder.sv | 111 +++++++++++
 tb/tb_mips_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder: loader FSM states,
// fault codes and the word size used for byte-to-word address conversion.
package mips_mem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } memState_t;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_FETCH = 2'b01;
    localparam logic [1:0] FAULT_DATA  = 2'b10;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mips_mem_loader.sv
// Program loader FSM: streams words into instruction memory after reset and
// holds the core in reset until the last beat (or a full memory) is accepted.
module mips_mem_loader
    import mips_mem_pkg::*;
#(
    parameter int IMEM_WORDS = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ld_valid,
    input  logic                          ld_last,
    output logic                          ld_ready,
    output logic                          core_reset,
    output logic                          running,
    output logic                          imemWe,
    output logic [$clog2(IMEM_WORDS)-1:0] ldPtr
);

    localparam int PW = $clog2(IMEM_WORDS);
    localparam logic [PW-1:0] LAST_PTR = PW'(IMEM_WORDS - 1);

    memState_t     state;
    memState_t     stateNext;
    logic [PW-1:0] ptrNext;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD;
            ldPtr <= '0;
        end else begin
            state <= stateNext;
            ldPtr <= ptrNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext  = state;
        ptrNext    = ldPtr;
        ld_ready   = 1'b0;
        core_reset = 1'b0;
        running    = 1'b0;
        imemWe     = 1'b0;
        case (state)
            LOAD: begin
                ld_ready   = 1'b1;
                core_reset = 1'b1;
                if (ld_valid) begin
                    // A beat presented while reset is high must not land in memory.
                    imemWe = !reset;
                    if (ld_last || ldPtr == LAST_PTR) begin
                        stateNext = RUN;
                    end else begin
                        ptrNext = ldPtr + 1'b1;
                    end
                end
            end
            RUN: begin
                running = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the single-cycle MIPS core: combinational imem/dmem
// reads, dmem stores, program loader, and optional fault capture (MIPS_MEM_FAULT_EN).
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] Instr,
    output logic [31:0] ReadData,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_reset,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr
);

    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);
    localparam int BA = $clog2(WORD_BYTES);

    logic [31:0]   imem [IMEM_WORDS];
    logic [31:0]   dmem [DMEM_WORDS];

    logic          running;
    logic          imemWe;
    logic [IA-1:0] ldPtr;
    logic          fetchOk;
    logic          dataOk;
    logic [IA-1:0] fetchIdx;
    logic [DA-1:0] dataIdx;

    mips_mem_loader #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_loader (
        .clock      (clock),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .core_reset (core_reset),
        .running    (running),
        .imemWe     (imemWe),
        .ldPtr      (ldPtr)
    );

    // An access is usable only if it is word aligned and inside the array.
    assign fetchOk  = (PC[31:IA+BA] == '0) && (PC[BA-1:0] == '0);
    assign dataOk   = (ALUOut[31:DA+BA] == '0) && (ALUOut[BA-1:0] == '0);
    assign fetchIdx = PC[IA+BA-1:BA];
    assign dataIdx  = ALUOut[DA+BA-1:BA];

    assign Instr    = fetchOk ? imem[fetchIdx] : '0;
    assign ReadData = dataOk  ? dmem[dataIdx]  : '0;

    // NOTE: the arrays have no reset, so a reload or core reset keeps data memory intact.
    always_ff @(posedge clock) begin
        if (imemWe) begin
            imem[ldPtr] <= ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (running && MemWrite && dataOk) begin
            dmem[dataIdx] <= WriteData;
        end
    end

`ifdef MIPS_MEM_FAULT_EN
    logic        faultQ;
    logic [1:0]  codeQ;
    logic [31:0] addrQ;

    // Only the first bad access is recorded; a fetch fault outranks a data fault.
    always_ff @(posedge clock) begin
        if (reset) begin
            faultQ <= 1'b0;
            codeQ  <= FAULT_NONE;
            addrQ  <= '0;
        end else if (running && !faultQ) begin
            if (!fetchOk) begin
                faultQ <= 1'b1;
                codeQ  <= FAULT_FETCH;
                addrQ  <= PC;
            end else if (MemWrite && !dataOk) begin
                faultQ <= 1'b1;
                codeQ  <= FAULT_DATA;
                addrQ  <= ALUOut;
            end
        end
    end

    assign fault      = faultQ;
    assign fault_code = codeQ;
    assign fault_addr = addrQ;
`else
    assign fault      = 1'b0;
    assign fault_code = FAULT_NONE;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: the driver pushes expectations from a
// behavioural memory model, a negedge monitor pops and compares them.
module tb_mips_mem_responder;
    import mips_mem_pkg::*;

    localparam int IW = 64;
    localparam int DW = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] PC, ALUOut, WriteData;
    logic        MemWrite;
    logic [31:0] Instr, ReadData;
    logic        ld_valid, ld_last, ld_ready, core_reset;
    logic [31:0] ld_data;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_addr;

    always #5 clock = ~clock;

    mips_mem_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .PC         (PC),
        .ALUOut     (ALUOut),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .Instr      (Instr),
        .ReadData   (ReadData),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .core_reset (core_reset),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_addr (fault_addr)
    );

    typedef enum int {K_INSTR, K_RDATA, K_CRST, K_LDRDY, K_FAULT, K_FCODE, K_FADDR} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cycle <= cycle + 1;

    // Behavioural model: plain arrays plus the loader/fault rules.
    logic [31:0] mImem[IW];
    logic [31:0] mDmem[DW];
    bit          iKnown[IW];
    bit          dKnown[DW];
    bit          mLoading;
    int          mBeats;
    bit          mFault;
    logic [1:0]  mCode;
    logic [31:0] mAddr;

    function automatic bit fetchGood(logic [31:0] a);
        return (a < 32'(4 * IW)) && (a % 4 == 0);
    endfunction

    function automatic bit dataGood(logic [31:0] a);
        return (a < 32'(4 * DW)) && (a % 4 == 0);
    endfunction

    task automatic expectOut(kind_t k, logic [31:0] v, string n);
        exp_t e;
        e.cyc  = cycle;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic modelReset();
        mLoading = 1'b1;
        mBeats   = 0;
        mFault   = 1'b0;
        mCode    = 2'b00;
        mAddr    = '0;
    endtask

    // Push this cycle's expected outputs, advance the model, then clock.
    task automatic step();
        expectOut(K_CRST,  32'(mLoading), "core_reset");
        expectOut(K_LDRDY, 32'(mLoading), "ld_ready");
        expectOut(K_FAULT, 32'(mFault),   "fault");
        expectOut(K_FCODE, 32'(mCode),    "fault_code");
        expectOut(K_FADDR, mAddr,         "fault_addr");
        if (!fetchGood(PC))               expectOut(K_INSTR, 32'h0, "Instr");
        else if (iKnown[int'(PC >> 2)])   expectOut(K_INSTR, mImem[int'(PC >> 2)], "Instr");
        if (!dataGood(ALUOut))            expectOut(K_RDATA, 32'h0, "ReadData");
        else if (dKnown[int'(ALUOut >> 2)]) expectOut(K_RDATA, mDmem[int'(ALUOut >> 2)], "ReadData");

        if (reset) begin
            modelReset();
        end else if (mLoading) begin
            if (ld_valid) begin
                mImem[mBeats]  = ld_data;
                iKnown[mBeats] = 1'b1;
                mBeats++;
                if (ld_last || mBeats == IW) mLoading = 1'b0;
            end
        end else begin
`ifdef MIPS_MEM_FAULT_EN
            if (!mFault && !fetchGood(PC)) begin
                mFault = 1'b1; mCode = 2'b01; mAddr = PC;
            end else if (!mFault && MemWrite && !dataGood(ALUOut)) begin
                mFault = 1'b1; mCode = 2'b10; mAddr = ALUOut;
            end
`endif
            if (MemWrite && dataGood(ALUOut)) begin
                mDmem[int'(ALUOut >> 2)]  = WriteData;
                dKnown[int'(ALUOut >> 2)] = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        MemWrite = 1'b0;
    endtask

    function automatic logic [31:0] randAddr(int words);
        if ($urandom_range(0, 9) != 0) return 32'($urandom_range(0, words - 1)) * 4;
        return $urandom;
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    exp_t        mon;
    logic [31:0] act;
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            mon = sb.pop_front();
            case (mon.kind)
                K_INSTR: act = Instr;
                K_RDATA: act = ReadData;
                K_CRST:  act = 32'(core_reset);
                K_LDRDY: act = 32'(ld_ready);
                K_FAULT: act = 32'(fault);
                K_FCODE: act = 32'(fault_code);
                default: act = fault_addr;
            endcase
            checks++;
            if (act !== mon.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", mon.name, mon.cyc, act, mon.exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; PC = '0; ALUOut = '0; WriteData = '0; MemWrite = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hBAD0_BAD0; ld_last = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        modelReset();
        step();  // reset values, with a beat offered during reset
        idle();

        // Full 64-beat load, no ld_last, with random gaps; word 3 is a nop.
        for (int i = 0; i < IW; ) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = (i == 3) ? 32'h0 : $urandom;
            PC       = 32'($urandom_range(0, IW - 1)) * 4;
            if (ld_valid) i++;
            step();
        end
        ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF; PC = '0;
        step();  // 65th beat ignored, already in RUN
        idle();
        step();

        // Fill data memory.
        for (int i = 0; i < DW; i++) begin
            MemWrite = 1'b1; ALUOut = 32'(i * 4); WriteData = $urandom;
            PC = 32'($urandom_range(0, IW - 1)) * 4;
            step();
        end

        // Store then read back at the same address.
        MemWrite = 1'b1; ALUOut = 32'h10; WriteData = 32'hDEAD_BEEF;
        step();
        MemWrite = 1'b0;
        step();

        // Misaligned and out-of-range stores are dropped.
        MemWrite = 1'b1; ALUOut = 32'h13;  WriteData = $urandom; step();
        MemWrite = 1'b1; ALUOut = 32'h400; WriteData = $urandom; step();
        MemWrite = 1'b0; ALUOut = 32'h10;  step();
        ALUOut = 32'h0;  step();
        ALUOut = 32'h12; step();

        // Random core traffic, including bad addresses.
        for (int i = 0; i < 150; i++) begin
            PC        = randAddr(IW);
            ALUOut    = randAddr(DW);
            MemWrite  = $urandom_range(0, 1) == 1;
            WriteData = $urandom;
            ld_valid  = $urandom_range(0, 1) == 1;
            ld_data   = $urandom;
            step();
        end
        idle();
        PC = '0;

        // Store, reset mid-RUN, reload a 3-beat program while stores are attempted.
        MemWrite = 1'b1; ALUOut = 32'h14; WriteData = 32'h0000_1234; step();
        MemWrite = 1'b0; reset = 1'b1; step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemWrite  = 1'b1; ALUOut = 32'h14; WriteData = 32'hFFFF_0000;
            ld_valid  = 1'b1; ld_last = (i == 2);
            ld_data   = (i == 0) ? 32'h2008_0005 : (i == 1) ? 32'h2009_0007 : 32'h0109_5020;
            PC        = 32'(i * 4);
            step();
        end
        idle();
        PC = 32'h8; ALUOut = 32'h14; step();
        PC = 32'hC; step();
        PC = 32'h0; step();
        PC = 32'h4; ALUOut = 32'h10; step();

        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
